// File: rtl/fifo_mac_if.sv
// Bundle between the MAC core, its two operand FIFOs and the result consumer.
// master = MAC core side, slave = FIFO/consumer side.
interface fifo_mac_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 18
);
  logic                  a_n_empty;
  logic [DATA_WIDTH-1:0] a_Dout;
  logic                  a_RE;
  logic                  b_n_empty;
  logic [DATA_WIDTH-1:0] b_Dout;
  logic                  b_RE;
  logic [ACC_WIDTH-1:0]  result;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;

  modport master (
    input  a_n_empty, a_Dout, b_n_empty, b_Dout, out_ready,
    output a_RE, b_RE, result, out_valid, busy
  );

  modport slave (
    output a_n_empty, a_Dout, b_n_empty, b_Dout, out_ready,
    input  a_RE, b_RE, result, out_valid, busy
  );
endinterface

// File: rtl/fifo_mac_core.sv
// Pops paired operands from two FIFOs, accumulates VEC_LEN unsigned products
// and holds the dot product on a valid/ready port until accepted.
module fifo_mac_core #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LEN    = 4,
  parameter int ACC_WIDTH  = 18
) (
  input  logic clk,
  input  logic rst_n,
  fifo_mac_if.master io
);
  localparam int CNT_W = $clog2(VEC_LEN + 1);
  localparam logic [CNT_W-1:0] VEC_LEN_C = CNT_W'(VEC_LEN);
  localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(VEC_LEN - 1);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]        acc_cnt_q, acc_cnt_d;
  logic                    rd_vld_q, rd_vld_d;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic [ACC_WIDTH-1:0]    result_q, result_d;
  logic                    out_valid_q, out_valid_d;

  logic                    re;
  logic                    complete;
  logic                    accept;
  logic [2*DATA_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]    sum;

  // Accumulation wraps modulo 2^ACC_WIDTH; the product is zero-extended.
  function automatic logic [ACC_WIDTH-1:0] mac_wrap(
    input logic [ACC_WIDTH-1:0]    acc,
    input logic [2*DATA_WIDTH-1:0] p
  );
    return acc + ACC_WIDTH'(p);
  endfunction

  always_comb begin
    prod     = (2*DATA_WIDTH)'(io.a_Dout) * (2*DATA_WIDTH)'(io.b_Dout);
    sum      = mac_wrap(acc_q, prod);
    complete = rd_vld_q && (acc_cnt_q == LAST_C);
    accept   = out_valid_q && io.out_ready;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (complete) state_d = HOLD;
      HOLD:    if (accept)   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Outputs: RE depends only on registered state and the FIFO flags
  always_comb begin
    re           = (state_q == RUN) && io.a_n_empty && io.b_n_empty &&
                   (issue_cnt_q < VEC_LEN_C);
    io.a_RE      = re;
    io.b_RE      = re;
    io.result    = result_q;
    io.out_valid = out_valid_q;
    io.busy      = (issue_cnt_q != '0) || rd_vld_q || (acc_cnt_q != '0);
  end

  // Issue/accumulate datapath next values
  always_comb begin
    issue_cnt_d = issue_cnt_q;
    acc_cnt_d   = acc_cnt_q;
    acc_d       = acc_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    rd_vld_d    = re;

    if (re) issue_cnt_d = issue_cnt_q + CNT_W'(1);

    if (rd_vld_q) begin
      acc_d     = sum;
      acc_cnt_d = acc_cnt_q + CNT_W'(1);
    end

    if (complete) begin
      result_d    = sum;
      out_valid_d = 1'b1;
      acc_d       = '0;
      acc_cnt_d   = '0;
      issue_cnt_d = '0;
    end

    if ((state_q == HOLD) && accept) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      acc_cnt_q   <= '0;
      rd_vld_q    <= 1'b0;
      acc_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      rd_vld_q    <= rd_vld_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fifo_mac_core.sv
// Directed bench for fifo_mac_core with a behavioural model of the two
// operand FIFOs (registered read data, one-cycle read latency).
module tb_fifo_mac_core;
  localparam int DW = 8;
  localparam int VL = 4;
  localparam int AW = 18;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  fifo_mac_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) io();

  fifo_mac_core #(.DATA_WIDTH(DW), .VEC_LEN(VL), .ACC_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;

  // FIFO model: written only by the stimulus, popped only on RE edges
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] wr_a = 8'd0, wr_b = 8'd0;
  logic [7:0] rd_a = 8'd0, rd_b = 8'd0;

  assign io.a_n_empty = (wr_a != rd_a);
  assign io.b_n_empty = (wr_b != rd_b);

  always @(posedge clk) begin
    if (io.a_RE && io.a_n_empty) begin
      io.a_Dout <= mem_a[rd_a];
      rd_a      <= rd_a + 8'd1;
    end
    if (io.b_RE && io.b_n_empty) begin
      io.b_Dout <= mem_b[rd_b];
      rd_b      <= rd_b + 8'd1;
    end
  end

  // Edge monitor: counts edges, logs RE edges, flags illegal pops
  int cyc    = 0;
  int re_cnt = 0;
  int viol   = 0;
  int re_cyc [256];

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    viol <= viol + int'(io.a_RE !== io.b_RE)
                 + int'((io.a_RE === 1'b1) && !(io.a_n_empty && io.b_n_empty))
                 + int'((io.a_RE === 1'b1) && (io.out_valid === 1'b1));
    if (io.a_RE === 1'b1) begin
      re_cyc[re_cnt] <= cyc + 1;
      re_cnt         <= re_cnt + 1;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_a(input logic [7:0] v);
    mem_a[wr_a] = v;
    wr_a        = wr_a + 8'd1;
  endtask

  task automatic push_b(input logic [7:0] v);
    mem_b[wr_b] = v;
    wr_b        = wr_b + 8'd1;
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
    push_a(a);
    push_b(b);
  endtask

  // All tasks below start and end just after a falling edge
  task automatic wait_valid(input string tag);
    for (int k = 0; k < 60 && io.out_valid !== 1'b1; k++) @(negedge clk);
    chk({tag, "_timeout"}, 32'(io.out_valid), 32'd1);
  endtask

  task automatic handshake(input string tag, output int h);
    io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;
    h = cyc;
    chk(tag, 32'(io.out_valid), 32'd0);
  endtask

  int base;
  int base2;
  int h;
  int busy_low;
  int unstable;

  initial begin
    io.out_ready = 1'b0;

    // Asynchronous reset with both FIFOs empty
    #1 rst_n = 1'b0;
    #1;
    chk("rst_a_re",      32'(io.a_RE),      32'd0);
    chk("rst_b_re",      32'(io.b_RE),      32'd0);
    chk("rst_result",    32'(io.result),    32'd0);
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_busy",      32'(io.busy),      32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_re",   32'(io.a_RE), 32'd0);
    chk("idle_busy", 32'(io.busy), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midcyc_rst_valid", 32'(io.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic dot product 1..4 . 5..8 = 70
    base = re_cnt;
    for (int i = 0; i < 4; i++) push_pair(8'(i + 1), 8'(i + 5));
    wait_valid("basic");
    chk("basic_re_cnt",  32'(re_cnt - base), 32'd4);
    chk("basic_re_span", 32'(re_cyc[re_cnt-1] - re_cyc[base]), 32'd3);
    chk("basic_latency", 32'(cyc - re_cyc[re_cnt-1]), 32'd1);
    chk("basic_result",  32'(io.result), 32'd70);
    chk("basic_busy_hold", 32'(io.busy), 32'd0);
    handshake("basic_accept", h);

    // Max operands: 4 * 255 * 255 = 260100, below 2^18
    for (int i = 0; i < 4; i++) push_pair(8'd255, 8'd255);
    wait_valid("max");
    chk("max_result", 32'(io.result), 32'd260100);
    handshake("max_accept", h);

    // Starved operand B with 5-cycle gaps
    for (int i = 0; i < 4; i++) push_a(8'(i + 1));
    push_b(8'd5);
    busy_low = 0;
    for (int b = 6; b <= 8; b++) begin
      repeat (5) begin
        @(negedge clk);
        if (io.busy !== 1'b1) busy_low++;
      end
      push_b(8'(b));
    end
    wait_valid("starve");
    chk("starve_result",   32'(io.result), 32'd70);
    chk("starve_busy_gap", 32'(busy_low),  32'd0);
    handshake("starve_accept", h);

    // Held output with a second vector already queued (1*2 x4 = 8)
    for (int i = 0; i < 4; i++) push_pair(8'(i + 1), 8'(i + 5));
    for (int i = 0; i < 4; i++) push_pair(8'd1, 8'd2);
    wait_valid("held");
    chk("held_result", 32'(io.result), 32'd70);
    base2    = re_cnt;
    unstable = 0;
    repeat (10) begin
      @(negedge clk);
      if (io.result !== 18'd70 || io.out_valid !== 1'b1) unstable++;
    end
    chk("held_stable", 32'(unstable), 32'd0);
    chk("held_no_re",  32'(re_cnt - base2), 32'd0);
    handshake("held_accept", h);
    wait_valid("second");
    chk("second_result",   32'(io.result), 32'd8);
    chk("second_first_re", 32'(re_cyc[base2] - h), 32'd1);
    handshake("second_accept", h);

    // Reset after two pops; the partial sum must not survive
    push_pair(8'd9, 8'd9);
    push_pair(8'd9, 8'd9);
    repeat (2) @(negedge clk);
    chk("midvec_busy", 32'(io.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midvec_rst_busy", 32'(io.busy), 32'd0);
    chk("midvec_rst_re",   32'(io.a_RE), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_pair(8'd1, 8'd1);
    wait_valid("fresh");
    chk("fresh_result", 32'(io.result), 32'd4);
    handshake("fresh_accept", h);

    repeat (2) @(negedge clk);
    chk("re_rules", 32'(viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
